// File: rtl/lcd_pkg.sv
// Shared definitions for the SmartLift LCD byte path: arbiter FSM encoding,
// requester indices and the HD44780-style command bytes used by requesters.
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DELAY = 2'd2,
    ST_ACK   = 2'd3
  } lcd_arb_state_e;

  // Requester indices on iREQ/iLOCK/oGNT/oACK
  localparam logic REQ_STATUS = 1'b0;  // elevator-status text sequencer
  localparam logic REQ_FLOOR  = 1'b1;  // floor/call-indicator writer

  // LCD controller command bytes
  localparam logic [7:0] LCD_CMD_FUNC_SET   = 8'h38;
  localparam logic [7:0] LCD_CMD_DISPLAY_ON = 8'h0C;
  localparam logic [7:0] LCD_CMD_CLEAR      = 8'h01;
  localparam logic [7:0] LCD_CMD_ENTRY_MODE = 8'h06;
  localparam logic [7:0] LCD_CMD_LINE1      = 8'h80;
  localparam logic [7:0] LCD_CMD_LINE2      = 8'hC0;

  // One-hot grant/ack vector for a requester index
  function automatic logic [1:0] req_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Post-byte settling timer: cleared when the controller reports done, counts
// while enabled and flags the last settling cycle.
module lcd_delay_timer #(
  parameter int unsigned DLY_CYCLES = 262142,
  parameter int unsigned DLY_W      = 18
) (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [DLY_W-1:0] TC_VAL = DLY_W'(DLY_CYCLES - 32'd1);

  logic [DLY_W-1:0] cnt_q;
  logic [DLY_W-1:0] cnt_d;

  // Next count: clear has priority over counting
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + {{(DLY_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Round-robin arbiter sharing one LCD byte controller between two requesters,
// with central post-byte settling delay and an owner lock for multi-byte runs.
module lcd_bus_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned DLY_CYCLES = 262142,
  parameter int unsigned DLY_W      = 18
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [1:0] iREQ,
  input  logic [1:0] iLOCK,
  input  logic [7:0] iDATA0,
  input  logic [7:0] iDATA1,
  input  logic       iRS0,
  input  logic       iRS1,
  output logic [1:0] oGNT,
  output logic [1:0] oACK,
  output logic [7:0] oLCD_DATA,
  output logic       oLCD_RS,
  output logic       oLCD_START,
  input  logic       iLCD_DONE
);

  lcd_arb_state_e state_q, state_d;
  logic [1:0] gnt_q, gnt_d;
  logic [1:0] ack_q, ack_d;
  logic [7:0] data_q, data_d;
  logic       rs_q, rs_d;
  logic       start_q, start_d;
  logic       lock_q, lock_d;
  logic       last_q, last_d;

  logic tmr_clr;
  logic tmr_en;
  logic tmr_tc;
  logic grant_v;
  logic sel;
  logic owner;

  // Owner of the byte in flight; grant is one-hot outside IDLE
  assign owner = gnt_q[1];

  lcd_delay_timer #(
    .DLY_CYCLES(DLY_CYCLES),
    .DLY_W     (DLY_W)
  ) u_dly (
    .iCLK  (iCLK),
    .iRST_N(iRST_N),
    .clr_i (tmr_clr),
    .en_i  (tmr_en),
    .tc_o  (tmr_tc)
  );

  // Next-state and output decode for the arbitration/issue sequence
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ack_d   = 2'b00;
    data_d  = data_q;
    rs_d    = rs_q;
    start_d = start_q;
    lock_d  = lock_q;
    last_d  = last_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    grant_v = 1'b0;
    sel     = last_q;
    case (state_q)
      ST_IDLE: begin
        if (lock_q) begin
          // Locked: only the previous owner may proceed; release once it is quiet
          if (iREQ[last_q]) begin
            grant_v = 1'b1;
            sel     = last_q;
          end else if (!iLOCK[last_q]) begin
            lock_d = 1'b0;
            gnt_d  = 2'b00;
          end else begin
            lock_d = 1'b1;
          end
        end else begin
          if (iREQ == 2'b11) begin
            grant_v = 1'b1;
            sel     = ~last_q;
          end else if (iREQ[REQ_STATUS]) begin
            grant_v = 1'b1;
            sel     = REQ_STATUS;
          end else if (iREQ[REQ_FLOOR]) begin
            grant_v = 1'b1;
            sel     = REQ_FLOOR;
          end else begin
            grant_v = 1'b0;
          end
        end
        if (grant_v) begin
          gnt_d   = req_onehot(sel);
          data_d  = sel ? iDATA1 : iDATA0;
          rs_d    = sel ? iRS1 : iRS0;
          start_d = 1'b1;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (iLCD_DONE) begin
          start_d = 1'b0;
          tmr_clr = 1'b1;
          state_d = ST_DELAY;
        end else begin
          start_d = 1'b1;
        end
      end
      ST_DELAY: begin
        tmr_en = 1'b1;
        if (tmr_tc) begin
          ack_d   = req_onehot(owner);
          state_d = ST_ACK;
        end else begin
          state_d = ST_DELAY;
        end
      end
      ST_ACK: begin
        last_d  = owner;
        lock_d  = iLOCK[owner];
        state_d = ST_IDLE;
        if (!iLOCK[owner]) begin
          gnt_d = 2'b00;
        end else begin
          gnt_d = gnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 2'b00;
        start_d = 1'b0;
        lock_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= ST_IDLE;
      gnt_q   <= 2'b00;
      ack_q   <= 2'b00;
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
      start_q <= 1'b0;
      lock_q  <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      start_q <= start_d;
      lock_q  <= lock_d;
      last_q  <= last_d;
    end
  end

  assign oGNT       = gnt_q;
  assign oACK       = ack_q;
  assign oLCD_DATA  = data_q;
  assign oLCD_RS    = rs_q;
  assign oLCD_START = start_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Self-checking bench for lcd_bus_arbiter with DLY_CYCLES = 4 and an LCD
// controller model that raises done in the 3rd cycle after start rises.
module tb_lcd_bus_arbiter;

  typedef struct packed {
    logic [7:0] data;
    logic       rs;
    logic       lock;
  } byte_t;

  typedef struct packed {
    logic       who;
    logic [7:0] data;
    logic       rs;
    logic       lock;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic [1:0] lock;
  logic [7:0] d0, d1;
  logic       rs0, rs1;
  logic [1:0] gnt, ack;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_start, lcd_done;
  logic       extra_done;

  logic [1:0] ctl_cnt;
  logic       ctl_done;

  int total = 0;
  int bad   = 0;

  byte_t q0[$];
  byte_t q1[$];

  always #5 clk = ~clk;

  lcd_bus_arbiter #(
    .DLY_CYCLES(4),
    .DLY_W     (18)
  ) dut (
    .iCLK      (clk),
    .iRST_N    (rst_n),
    .iREQ      (req),
    .iLOCK     (lock),
    .iDATA0    (d0),
    .iDATA1    (d1),
    .iRS0      (rs0),
    .iRS1      (rs1),
    .oGNT      (gnt),
    .oACK      (ack),
    .oLCD_DATA (lcd_data),
    .oLCD_RS   (lcd_rs),
    .oLCD_START(lcd_start),
    .iLCD_DONE (lcd_done)
  );

  // LCD controller model: done is high in the 3rd cycle after start rises
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_cnt  <= 2'd0;
      ctl_done <= 1'b0;
    end else if (!lcd_start) begin
      ctl_cnt  <= 2'd0;
      ctl_done <= 1'b0;
    end else begin
      ctl_cnt  <= ctl_cnt + 2'd1;
      ctl_done <= (ctl_cnt == 2'd2);
    end
  end

  assign lcd_done = ctl_done | extra_done;

  function automatic logic [1:0] oh(input logic w);
    return w ? 2'b10 : 2'b01;
  endfunction

  task automatic test_reset();
    rst_n = 1'b1; req = 2'b00; lock = 2'b00; d0 = 8'h00; d1 = 8'h00;
    rs0 = 1'b0; rs1 = 1'b0; extra_done = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({gnt, ack, lcd_data, lcd_rs, lcd_start} !== 14'd0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", {gnt, ack, lcd_data, lcd_rs, lcd_start});
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({gnt, ack, lcd_data, lcd_rs, lcd_start} !== 14'd0) begin
      bad++; $display("FAIL idle_after_reset got=%h want=0", {gnt, ack, lcd_data, lcd_rs, lcd_start});
    end
  endtask

  task automatic test_single();
    int  n;
    logic seen;
    d0 = 8'h41; rs0 = 1'b1; req = 2'b01;
    @(negedge clk);
    total++;
    if ({lcd_start, lcd_rs, lcd_data, gnt} !== {1'b1, 1'b1, 8'h41, 2'b01}) begin
      bad++; $display("FAIL single_issue got start=%b rs=%b data=%h gnt=%b want 1 1 41 01",
                      lcd_start, lcd_rs, lcd_data, gnt);
    end
    n = 0; seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (lcd_start === 1'b0) begin seen = 1'b1; n = i; end
    end
    total++;
    if (n != 4) begin bad++; $display("FAIL single_start_fall got=%0d want=4 cycles", n); end
    n = 0; seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (ack !== 2'b00) begin seen = 1'b1; n = i; end
    end
    total++;
    if (n != 4) begin bad++; $display("FAIL single_ack_delay got=%0d want=4 cycles", n); end
    total++;
    if (ack !== 2'b01) begin bad++; $display("FAIL single_ack_value got=%b want=01", ack); end
    req = 2'b00; rs0 = 1'b0;
    @(negedge clk);
    total++;
    if ({gnt, ack, lcd_start} !== 5'd0) begin
      bad++; $display("FAIL single_back_to_idle got gnt=%b ack=%b start=%b want 0", gnt, ack, lcd_start);
    end
  endtask

  task automatic test_drop_req();
    int   rises;
    int   acks;
    logic prev;
    logic [1:0] ackv;
    d0 = 8'h5A; rs0 = 1'b0; req = 2'b01;
    @(negedge clk);
    req = 2'b00;
    rises = 0; acks = 0; ackv = 2'b00; prev = lcd_start;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (lcd_start && !prev) rises++;
      prev = lcd_start;
      if (ack !== 2'b00) begin acks++; ackv = ack; end
    end
    total++;
    if (acks != 1 || ackv !== 2'b01) begin
      bad++; $display("FAIL drop_req_ack got count=%0d value=%b want 1 01", acks, ackv);
    end
    total++;
    if (rises != 0) begin bad++; $display("FAIL drop_req_restart got=%0d want=0", rises); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    d0 = 8'h11; rs0 = 1'b1; req = 2'b01;
    @(negedge clk);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (lcd_start === 1'b0) seen = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({gnt, ack, lcd_data, lcd_rs, lcd_start} !== 14'd0) begin
      bad++; $display("FAIL reset_mid_outputs got=%h want=0", {gnt, ack, lcd_data, lcd_rs, lcd_start});
    end
    d0 = 8'h22; rs0 = 1'b0; d1 = 8'h33; rs1 = 1'b1; req = 2'b11;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({lcd_start, gnt, lcd_data, lcd_rs} !== {1'b1, 2'b01, 8'h22, 1'b0}) begin
      bad++; $display("FAIL reset_mid_first_grant got start=%b gnt=%b data=%h rs=%b want 1 01 22 0",
                      lcd_start, gnt, lcd_data, lcd_rs);
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ack !== 2'b00) seen = 1'b1;
    end
    total++;
    if (ack !== 2'b01) begin bad++; $display("FAIL reset_mid_ack0 got=%b want=01", ack); end
    req = 2'b10;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ack !== 2'b00) seen = 1'b1;
    end
    total++;
    if (ack !== 2'b10) begin bad++; $display("FAIL reset_mid_ack1 got=%b want=10", ack); end
    req = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_done_idle();
    int   hits;
    logic seen;
    req = 2'b00;
    @(negedge clk);
    extra_done = 1'b1;
    @(negedge clk);
    extra_done = 1'b0;
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if ({gnt, ack, lcd_start} !== 5'd0) hits++;
    end
    total++;
    if (hits != 0) begin bad++; $display("FAIL done_idle_activity got=%0d want=0 cycles", hits); end
    d1 = 8'hC0; rs1 = 1'b0; req = 2'b10;
    @(negedge clk);
    total++;
    if ({lcd_start, gnt, lcd_data} !== {1'b1, 2'b10, 8'hC0}) begin
      bad++; $display("FAIL done_idle_next_grant got start=%b gnt=%b data=%h want 1 10 c0",
                      lcd_start, gnt, lcd_data);
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ack !== 2'b00) seen = 1'b1;
    end
    total++;
    if (ack !== 2'b10) begin bad++; $display("FAIL done_idle_ack got=%b want=10", ack); end
    req = 2'b00;
    @(negedge clk);
  endtask

  // Plays q0/q1 through the DUT after a reset and checks every byte against a
  // transaction-level prediction of service order and cycle timing.
  task automatic run_traffic(input string name);
    exp_t exp_q[$];
    exp_t e;
    int   i0, i1, n, k_start, k_ack, s_cyc, budget;
    logic last, lk, who, p0, p1;
    logic pending, prev_start, chk_gnt, pop0, pop1;
    logic [1:0] prev_ack, gnt_after;

    i0 = 0; i1 = 0; last = 1'b1; lk = 1'b0;
    while (i0 < q0.size() || i1 < q1.size()) begin
      p0 = (i0 < q0.size());
      p1 = (i1 < q1.size());
      if (lk && (last ? p1 : p0)) who = last;
      else if (p0 && p1) who = ~last;
      else who = p1;
      if (who) begin e = {1'b1, q1[i1].data, q1[i1].rs, q1[i1].lock}; i1++; end
      else begin e = {1'b0, q0[i0].data, q0[i0].rs, q0[i0].lock}; i0++; end
      exp_q.push_back(e);
      last = who;
      lk   = e.lock;
    end
    n = exp_q.size();

    @(negedge clk);
    req = 2'b00; lock = 2'b00; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    k_start = 0; k_ack = 0; s_cyc = 0; budget = n * 12 + 40;
    pending = 1'b0; prev_start = 1'b0; chk_gnt = 1'b0; pop0 = 1'b0; pop1 = 1'b0;
    prev_ack = 2'b00; gnt_after = 2'b00;

    for (int c = 0; c < budget && k_ack < n; c++) begin
      @(negedge clk);
      if (pop0 && q0.size() > 0) void'(q0.pop_front());
      if (pop1 && q1.size() > 0) void'(q1.pop_front());
      pop0 = 1'b0; pop1 = 1'b0;
      req[0] = (q0.size() > 0);
      req[1] = (q1.size() > 0);
      if (q0.size() > 0) begin d0 = q0[0].data; rs0 = q0[0].rs; lock[0] = q0[0].lock; end
      else lock[0] = 1'b0;
      if (q1.size() > 0) begin d1 = q1[0].data; rs1 = q1[0].rs; lock[1] = q1[0].lock; end
      else lock[1] = 1'b0;

      if (chk_gnt) begin
        total++;
        if (gnt !== gnt_after) begin
          bad++; $display("FAIL %s gnt_after_ack got=%b want=%b", name, gnt, gnt_after);
        end
        chk_gnt = 1'b0;
      end
      if (lcd_start && !prev_start) begin
        total++;
        if (pending || k_start >= n) begin
          bad++; $display("FAIL %s unexpected_start got byte %0d want none", name, k_start);
        end else if ({gnt, lcd_data, lcd_rs} !== {oh(exp_q[k_start].who), exp_q[k_start].data,
                                                  exp_q[k_start].rs}) begin
          bad++; $display("FAIL %s grant_%0d got gnt=%b data=%h rs=%b want gnt=%b data=%h rs=%b",
                          name, k_start, gnt, lcd_data, lcd_rs, oh(exp_q[k_start].who),
                          exp_q[k_start].data, exp_q[k_start].rs);
        end
        pending = 1'b1; s_cyc = c; k_start++;
      end
      if (!lcd_start && prev_start) begin
        total++;
        if (c != s_cyc + 4) begin
          bad++; $display("FAIL %s start_fall got=%0d want=%0d", name, c - s_cyc, 4);
        end
      end
      if (ack !== 2'b00) begin
        total++;
        if (!pending || k_ack >= n || c != s_cyc + 8 || prev_ack !== 2'b00 ||
            ack !== oh(exp_q[k_ack].who)) begin
          bad++; $display("FAIL %s ack_%0d got ack=%b at +%0d want single pulse at +8 to byte owner",
                          name, k_ack, ack, c - s_cyc);
        end
        if (k_ack < n) gnt_after = exp_q[k_ack].lock ? oh(exp_q[k_ack].who) : 2'b00;
        chk_gnt = 1'b1;
        pending = 1'b0;
        k_ack++;
        pop0 = ack[0];
        pop1 = ack[1];
      end
      prev_start = lcd_start;
      prev_ack   = ack;
    end
    total++;
    if (k_ack != n) begin bad++; $display("FAIL %s completion got=%0d want=%0d bytes", name, k_ack, n); end
    req = 2'b00; lock = 2'b00;
    q0.delete(); q1.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_alternate();
    byte_t b;
    for (int i = 0; i < 4; i++) begin
      b = {8'($urandom), 1'($urandom), 1'b0}; q0.push_back(b);
      b = {8'($urandom), 1'($urandom), 1'b0}; q1.push_back(b);
    end
    run_traffic("alternate");
  endtask

  task automatic test_lock();
    byte_t b;
    for (int i = 0; i < 3; i++) begin
      b = {8'($urandom), 1'($urandom), 1'b0}; q0.push_back(b);
    end
    b = {8'hC0, 1'b0, 1'b1}; q1.push_back(b);
    b = {8'h33, 1'b1, 1'b1}; q1.push_back(b);
    b = {8'h2B, 1'b1, 1'b1}; q1.push_back(b);
    run_traffic("lock");
  endtask

  task automatic test_random();
    byte_t b;
    int    n0, n1;
    for (int r = 0; r < 3; r++) begin
      n0 = $urandom_range(1, 6);
      n1 = $urandom_range(1, 6);
      for (int i = 0; i < n0; i++) begin
        b = {8'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0)}; q0.push_back(b);
      end
      for (int i = 0; i < n1; i++) begin
        b = {8'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0)}; q1.push_back(b);
      end
      run_traffic("random");
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_drop_req();
    test_reset_mid();
    test_done_idle();
    test_alternate();
    test_lock();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
